riscv_dmem_ctrl: RTL and testbench
==================================

// Module: riscv_dmem_ctrl
// PURPOSE
//  Data-memory access controller between the M stage and a multi-cycle data memory.
//  Arbitrates M-stage loads/stores against a DMA/debug port and drives a req/ack memory handshake.
//  Stalls the pipeline until the CPU access completes.
//  Bounds every access with a timeout and reports an error on expiry.
// PARAMETERS
//  XLEN     32  data/address width
//  TIMEOUT  15  max cycles from o_mem_req rising to i_mem_ack; range 1..255
// PORTS
//  i_clk           in   1     clock, rising edge
//  i_rst           in   1     asynchronous reset, active-high
//  i_cpu_req       in   1     M-stage memory op valid; held until o_cpu_stall is low
//  i_cpu_wr_en     in   1     1=store, 0=load
//  i_cpu_byte_sel  in   4     byte lanes for the CPU access
//  i_cpu_addr      in   XLEN  CPU address (ALU result)
//  i_cpu_wdata     in   XLEN  CPU store data
//  o_cpu_rdata     out  XLEN  CPU load data; valid in the cycle o_cpu_stall falls
//  o_cpu_stall     out  1     freeze the pipeline
//  o_cpu_err       out  1     1-cycle pulse: the CPU access timed out
//  i_dma_req       in   1     DMA access request; held until o_dma_done
//  i_dma_wr_en     in   1     1=write, 0=read; DMA always uses byte_sel 4'b1111
//  i_dma_addr      in   XLEN  DMA address
//  i_dma_wdata     in   XLEN  DMA write data
//  o_dma_done      out  1     1-cycle pulse: DMA access finished (ack or timeout)
//  o_dma_err       out  1     1-cycle pulse with o_dma_done on timeout
//  o_dma_rdata     out  XLEN  DMA read data; valid while o_dma_done is high
//  o_mem_req       out  1     memory request; held high until ack or timeout
//  o_mem_wr_en     out  1     memory write enable
//  o_mem_byte_sel  out  4     memory byte lanes
//  o_mem_addr      out  XLEN  memory address
//  o_mem_wdata     out  XLEN  memory write data
//  i_mem_ack       in   1     memory done; read data valid in the same cycle
//  i_mem_rdata     in   XLEN  memory read data
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE; last_owner=DMA, so the CPU wins the first tie.
//   - All o_mem_*, o_dma_*, o_cpu_err and o_cpu_rdata are 0; timeout counter is 0.
//  FSM states: IDLE, CPU_ACC, DMA_ACC.
//  IDLE:
//   - If any request is pending, grant it. On a tie, grant the requester that is not last_owner.
//   - Latch the granted request into the o_mem_* registers and set o_mem_req=1 on the next edge.
//   - Go to CPU_ACC or DMA_ACC and clear the counter.
//  CPU_ACC / DMA_ACC:
//   - o_mem_* are stable and the counter increments every cycle.
//   - i_mem_ack=1: register i_mem_rdata to the owner's rdata, drop o_mem_req, set last_owner, return to IDLE.
//   - Counter==TIMEOUT with no ack: drop o_mem_req, pulse the owner's error (DMA also gets done), return to IDLE.
//  Latency: request in IDLE -> o_mem_req 1 cycle later -> done at ack+0. Minimum 2 cycles per access.
//  Back-to-back: a request cannot be granted on the cycle the previous access completes.
//   - IDLE lasts at least 1 cycle, so o_mem_req is low for at least 1 cycle between accesses.
//  o_cpu_stall is combinational:
//   - stall = i_cpu_req & ~(state==CPU_ACC & (i_mem_ack | timeout)).
//   - Timeout therefore releases the stall together with o_cpu_err.
//  o_cpu_rdata = i_mem_rdata in the releasing cycle (combinational bypass), registered copy otherwise.
//  CPU store: the write completes when the stall releases; no data is returned.
//  Ack outside CPU_ACC/DMA_ACC is ignored.
//  Ack and timeout in the same cycle: ack wins, no error.
//  Request withdrawn mid-access: the access still completes; done/err still pulse.
//  Reset mid-access: o_mem_req drops immediately; the in-flight access is abandoned with no done/err.
// TESTING
//  1. CPU load 0x100, memory acks 3 cycles after req, rdata 0xDEADBEEF
//     -> stall high 4 cycles; o_cpu_rdata=0xDEADBEEF on release.
//  2. CPU and DMA request in the same cycle after reset
//     -> CPU granted first, DMA next; o_mem_req low 1 cycle between them.
//  3. Continuous CPU and DMA requests
//     -> grants alternate CPU, DMA, CPU, DMA; neither starves.
//  4. DMA write, memory never acks, TIMEOUT=15
//     -> o_mem_req high 15 cycles, then o_dma_done=o_dma_err=1 for 1 cycle.
//  5. CPU store sel=4'b0011 addr 0x204, ack and timeout in the same cycle
//     -> stall releases, o_cpu_err=0, o_mem_byte_sel=4'b0011 throughout.
//  6. Assert i_rst during DMA_ACC
//     -> o_mem_req=0 asynchronously; after release, a CPU request is granted within 1 cycle.

Source files
------------

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory access controller: arbitrates M-stage and DMA requests onto a
// single req/ack memory port, stalls the CPU, and bounds each access with a timeout.
module riscv_dmem_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cpu_req,
    input  logic            i_cpu_wr_en,
    input  logic [3:0]      i_cpu_byte_sel,
    input  logic [XLEN-1:0] i_cpu_addr,
    input  logic [XLEN-1:0] i_cpu_wdata,
    output logic [XLEN-1:0] o_cpu_rdata,
    output logic            o_cpu_stall,
    output logic            o_cpu_err,
    input  logic            i_dma_req,
    input  logic            i_dma_wr_en,
    input  logic [XLEN-1:0] i_dma_addr,
    input  logic [XLEN-1:0] i_dma_wdata,
    output logic            o_dma_done,
    output logic            o_dma_err,
    output logic [XLEN-1:0] o_dma_rdata,
    output logic            o_mem_req,
    output logic            o_mem_wr_en,
    output logic [3:0]      o_mem_byte_sel,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    // Counter is 0 in the first cycle o_mem_req is high, so the timeout
    // fires in the TIMEOUT-th cycle of the request.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    logic            lastOwnerDma;
    logic [7:0]      cnt;
    logic [XLEN-1:0] cpuRdataQ;
    logic            timeout;
    logic            cpuRelease;
    logic            grantCpu;
    logic            grantDma;

    assign timeout    = (state != IDLE) && (cnt == CNT_LAST);
    assign cpuRelease = (state == CPU_ACC) && (i_mem_ack || timeout);
    assign grantCpu   = i_cpu_req && (!i_dma_req || lastOwnerDma);
    assign grantDma   = i_dma_req && !grantCpu;

    assign o_cpu_stall = i_cpu_req && !cpuRelease;
    assign o_cpu_err   = (state == CPU_ACC) && timeout && !i_mem_ack;
    assign o_cpu_rdata = cpuRelease ? i_mem_rdata : cpuRdataQ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            lastOwnerDma   <= 1'b1;
            cnt            <= '0;
            cpuRdataQ      <= '0;
            o_dma_done     <= 1'b0;
            o_dma_err      <= 1'b0;
            o_dma_rdata    <= '0;
            o_mem_req      <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_mem_byte_sel <= '0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
        end else begin
            o_dma_done <= 1'b0;
            o_dma_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grantCpu) begin
                        o_mem_req      <= 1'b1;
                        o_mem_wr_en    <= i_cpu_wr_en;
                        o_mem_byte_sel <= i_cpu_byte_sel;
                        o_mem_addr     <= i_cpu_addr;
                        o_mem_wdata    <= i_cpu_wdata;
                        state          <= CPU_ACC;
                    end else if (grantDma) begin
                        o_mem_req      <= 1'b1;
                        o_mem_wr_en    <= i_dma_wr_en;
                        o_mem_byte_sel <= 4'b1111;
                        o_mem_addr     <= i_dma_addr;
                        o_mem_wdata    <= i_dma_wdata;
                        state          <= DMA_ACC;
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    cnt <= cnt + 8'd1;
                    // Ack has priority over a coincident timeout.
                    if (i_mem_ack) begin
                        o_mem_req    <= 1'b0;
                        lastOwnerDma <= (state == DMA_ACC);
                        if (state == DMA_ACC) begin
                            o_dma_rdata <= i_mem_rdata;
                            o_dma_done  <= 1'b1;
                        end else if (!o_mem_wr_en) begin
                            cpuRdataQ <= i_mem_rdata;
                        end
                        state <= IDLE;
                    end else if (timeout) begin
                        o_mem_req <= 1'b0;
                        if (state == DMA_ACC) begin
                            o_dma_done <= 1'b1;
                            o_dma_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl: arbitration, latency, timeout and reset cases.
module tb_riscv_dmem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_cpu_req, i_cpu_wr_en;
    logic [3:0]  i_cpu_byte_sel;
    logic [31:0] i_cpu_addr, i_cpu_wdata, o_cpu_rdata;
    logic        o_cpu_stall, o_cpu_err;
    logic        i_dma_req, i_dma_wr_en;
    logic [31:0] i_dma_addr, i_dma_wdata, o_dma_rdata;
    logic        o_dma_done, o_dma_err;
    logic        o_mem_req, o_mem_wr_en;
    logic [3:0]  o_mem_byte_sel;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    riscv_dmem_ctrl #(.XLEN(32), .TIMEOUT(15)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_wr_en(i_cpu_wr_en), .i_cpu_byte_sel(i_cpu_byte_sel),
        .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata), .o_cpu_rdata(o_cpu_rdata),
        .o_cpu_stall(o_cpu_stall), .o_cpu_err(o_cpu_err),
        .i_dma_req(i_dma_req), .i_dma_wr_en(i_dma_wr_en), .i_dma_addr(i_dma_addr),
        .i_dma_wdata(i_dma_wdata), .o_dma_done(o_dma_done), .o_dma_err(o_dma_err),
        .o_dma_rdata(o_dma_rdata), .o_mem_req(o_mem_req), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_byte_sel(o_mem_byte_sel), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_cpu_req = 0; i_cpu_wr_en = 0; i_cpu_byte_sel = 4'hF; i_cpu_addr = 0; i_cpu_wdata = 0;
        i_dma_req = 0; i_dma_wr_en = 0; i_dma_addr = 0; i_dma_wdata = 0;
        i_mem_ack = 0; i_mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", 32'(o_mem_req), 0);
        chk("rst_stall", 32'(o_cpu_stall), 0);
        chk("rst_cpu_rdata", o_cpu_rdata, 0);
        chk("rst_dma_done", 32'(o_dma_done), 0);
        chk("rst_cpu_err", 32'(o_cpu_err), 0);
        chk("rst_mem_addr", o_mem_addr, 0);

        // 1: CPU load, ack 3 cycles after req rises; stall high 4 cycles
        i_rst = 1'b0;
        tick();
        i_cpu_req = 1; i_cpu_addr = 32'h100; #1;
        chk("t1_stall_c0", 32'(o_cpu_stall), 1);
        chk("t1_req_c0", 32'(o_mem_req), 0);
        tick();
        chk("t1_req_c1", 32'(o_mem_req), 1);
        chk("t1_addr", o_mem_addr, 32'h100);
        chk("t1_stall_c1", 32'(o_cpu_stall), 1);
        tick();
        chk("t1_stall_c2", 32'(o_cpu_stall), 1);
        tick();
        chk("t1_stall_c3", 32'(o_cpu_stall), 1);
        tick();
        i_mem_ack = 1; i_mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_stall_rel", 32'(o_cpu_stall), 0);
        chk("t1_rdata_byp", o_cpu_rdata, 32'hDEADBEEF);
        tick();
        i_cpu_req = 0; i_mem_ack = 0; i_mem_rdata = 0; #1;
        chk("t1_req_drop", 32'(o_mem_req), 0);
        chk("t1_rdata_reg", o_cpu_rdata, 32'hDEADBEEF);

        // 2: simultaneous CPU and DMA after reset -> CPU first, 1-cycle gap, DMA
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_cpu_req = 1; i_cpu_addr = 32'h10;
        i_dma_req = 1; i_dma_addr = 32'h20; i_dma_wr_en = 0;
        tick();
        chk("t2_first_addr", o_mem_addr, 32'h10);
        chk("t2_first_req", 32'(o_mem_req), 1);
        tick();
        i_mem_ack = 1; i_mem_rdata = 32'h11; #1;
        chk("t2_cpu_rdata", o_cpu_rdata, 32'h11);
        tick();
        i_cpu_req = 0; i_mem_ack = 0; #1;
        chk("t2_gap", 32'(o_mem_req), 0);
        tick();
        chk("t2_second_addr", o_mem_addr, 32'h20);
        chk("t2_dma_sel", 32'(o_mem_byte_sel), 32'hF);
        chk("t2_done_early", 32'(o_dma_done), 0);
        i_mem_ack = 1; i_mem_rdata = 32'h22;
        tick();
        i_dma_req = 0; i_mem_ack = 0; #1;
        chk("t2_dma_done", 32'(o_dma_done), 1);
        chk("t2_dma_err", 32'(o_dma_err), 0);
        chk("t2_dma_rdata", o_dma_rdata, 32'h22);

        // 3: continuous requests alternate CPU, DMA, CPU, DMA
        i_cpu_req = 1; i_cpu_addr = 32'h30;
        i_dma_req = 1; i_dma_addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_owner", o_mem_addr, (i % 2 == 0) ? 32'h30 : 32'h40);
            i_mem_ack = 1;
            tick();
            i_mem_ack = 0; #1;
            chk("t3_gap", 32'(o_mem_req), 0);
        end
        i_cpu_req = 0; i_dma_req = 0;

        // 4: DMA write never acked -> req high 15 cycles, then done+err
        tick();
        i_dma_req = 1; i_dma_wr_en = 1; i_dma_addr = 32'h44; i_dma_wdata = 32'h55;
        tick();
        for (int k = 1; k <= 15; k++) begin
            chk("t4_req_high", 32'(o_mem_req), 1);
            chk("t4_no_done", 32'(o_dma_done), 0);
            tick();
        end
        chk("t4_req_low", 32'(o_mem_req), 0);
        chk("t4_done", 32'(o_dma_done), 1);
        chk("t4_err", 32'(o_dma_err), 1);
        i_dma_req = 0; i_dma_wr_en = 0;
        tick();
        chk("t4_done_pulse", 32'(o_dma_done), 0);

        // 5: CPU store, ack coincides with timeout -> no error
        i_cpu_req = 1; i_cpu_wr_en = 1; i_cpu_byte_sel = 4'b0011; i_cpu_addr = 32'h204;
        tick();
        for (int k = 1; k <= 14; k++) begin
            chk("t5_sel", 32'(o_mem_byte_sel), 32'h3);
            chk("t5_stall", 32'(o_cpu_stall), 1);
            tick();
        end
        i_mem_ack = 1; #1;
        chk("t5_stall_rel", 32'(o_cpu_stall), 0);
        chk("t5_no_err", 32'(o_cpu_err), 0);
        chk("t5_sel_last", 32'(o_mem_byte_sel), 32'h3);
        tick();
        i_mem_ack = 0; i_cpu_req = 0; i_cpu_wr_en = 0; i_cpu_byte_sel = 4'hF; #1;
        chk("t5_req_low", 32'(o_mem_req), 0);

        // 5b: CPU load times out -> stall releases with err pulse
        i_cpu_req = 1; i_cpu_addr = 32'h208;
        tick();
        for (int k = 1; k <= 14; k++) tick();
        chk("t5b_stall_rel", 32'(o_cpu_stall), 0);
        chk("t5b_err", 32'(o_cpu_err), 1);
        tick();
        i_cpu_req = 0; #1;
        chk("t5b_err_pulse", 32'(o_cpu_err), 0);

        // 6: reset during DMA_ACC drops req asynchronously
        i_dma_req = 1; i_dma_addr = 32'h80;
        tick();
        chk("t6_dma_req", 32'(o_mem_req), 1);
        #2 i_rst = 1'b1; #1;
        chk("t6_async_drop", 32'(o_mem_req), 0);
        chk("t6_no_done", 32'(o_dma_done), 0);
        i_dma_req = 0; i_cpu_req = 1; i_cpu_addr = 32'h300;
        tick();
        i_rst = 1'b0;
        tick();
        chk("t6_cpu_grant", 32'(o_mem_req), 1);
        chk("t6_cpu_addr", o_mem_addr, 32'h300);
        i_mem_ack = 1;
        tick();
        i_mem_ack = 0; i_cpu_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
